frame_mux: RTL and testbench
============================

FRAME_MUX -- requirements
Module: frame_mux

Interface
REQ-001 Parameter WIDTH, default 12, sample width (two's complement) of every re/im bus.
REQ-002 Parameter PRE_LEN, default 320, preamble samples per frame.
REQ-003 Parameter FIFO_DEPTH, default 64, signal/payload buffer depth in samples (power of two).
REQ-004 Parameter OUT_DIV, default 3, clock cycles per output sample slot.
REQ-005 Parameter GAP_LEN, default 16, zero samples appended after a frame (Configuration only).
REQ-006 clk  in  1  system clock; all logic on rising edge; one clock domain.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 frame_start  in  1  single-cycle pulse that requests a new frame.
REQ-009 pld_len  in  14  signal+payload sample count, sampled with frame_start.
REQ-010 di_preamble_re / di_preamble_im  in  WIDTH  preamble sample.
REQ-011 di_preamble_vld  in  1  preamble sample valid; di_preamble_rdy  out  1  preamble accept.
REQ-012 di_sigpld_re / di_sigpld_im  in  WIDTH  signal/payload sample.
REQ-013 di_sigpld_vld  in  1  sample valid; di_sigpld_rdy  out  1  sample accept (= FIFO not full).
REQ-014 do_re / do_im  out  WIDTH  assembled frame sample; do_vld  out  1  sample valid; do_last  out  1  final frame sample.
REQ-015 busy  out  1  high whenever state is not IDLE; underrun  out  1  sticky underrun flag.

Function
REQ-016 States IDLE, PRE, PLD, GAP; a transfer occurs on any cycle where vld and rdy are both high.
REQ-017 IDLE: frame_start latches pld_len and enters PRE next cycle; frame_start outside IDLE is ignored.
REQ-018 Slot counter runs 0..OUT_DIV-1 from 0 on entering PRE; a slot is open when the counter is 0, and the counter holds at 0 while an open slot is unfilled.
REQ-019 PRE: di_preamble_rdy high only during open slots; each accepted sample appears on do_re/do_im with do_vld exactly 1 cycle later.
REQ-020 After PRE_LEN preamble samples, enter PLD; if latched pld_len is 0, skip PLD.
REQ-021 Sigpld FIFO accepts pushes in every state whenever not full; di_sigpld_rdy is registered, so a full FIFO refuses a push even when a pop occurs in the same cycle.
REQ-022 PLD: each open slot with the FIFO non-empty pops one sample, output with do_vld 1 cycle later; after pld_len pops, leave PLD.
REQ-023 An open slot in PLD with the FIFO empty sets underrun; it stays set until the next accepted frame_start and no output is produced for that slot.
REQ-024 do_last accompanies the final data sample of the frame (last preamble sample when pld_len is 0).
REQ-025 do_vld is a single-cycle pulse per sample; do_re/do_im hold their last value while do_vld is low.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is exact at full and at empty.
REQ-027 On leaving PLD (or PRE when pld_len is 0), enter GAP when compiled in, otherwise IDLE.

Reset
REQ-028 rst forces IDLE, clears all counters and FIFO pointers, and drives every output to 0, including both rdy outputs.
REQ-029 rst asserted mid-frame aborts the frame and discards any buffered samples; no do_vld occurs until a new frame_start.

Configuration
REQ-030 With macro FRAME_MUX_GAP_EN defined, GAP emits GAP_LEN zero samples (one per slot, do_vld high, do_last low), then returns to IDLE.
REQ-031 Without FRAME_MUX_GAP_EN, GAP is unreachable and the block returns to IDLE 1 cycle after the final sample.

Verification
REQ-032 Reset: rst=1 mid-PRE -> all outputs 0 immediately; after release, busy=0 and no do_vld until frame_start.
REQ-033 Nominal: pld_len=100, preamble and FIFO always ready -> 420 do_vld pulses spaced 3 cycles apart, preamble first, do_last on the 420th pulse, busy falls afterwards.
REQ-034 Backpressure: push 70 sigpld samples before frame_start -> di_sigpld_rdy low after 64 samples, no loss, output order is preserved.
REQ-035 Underrun: pld_len=10 with only 5 samples supplied -> underrun=1 after 5 payload outputs; the state machine waits in PLD, and the frame completes once 5 more samples arrive.
REQ-036 pld_len=0 -> exactly 320 outputs, do_last on sample 320; frame_start while busy is ignored.
REQ-037 With FRAME_MUX_GAP_EN, pld_len=4 -> 324 data samples followed by 16 zero samples, then IDLE.

Source files
------------

// File: rtl/frame_mux_if.sv
// ---------------------------------------------------------------------------
// frame_mux_if -- bundle of all frame_mux handshake, data and status signals.
//
// Parameter
//   WIDTH : sample width of every re/im bus (two's complement); it must match
//           the WIDTH of the frame_mux instance that uses this interface.
//
// Signals (direction as seen by the frame_mux, i.e. the slave modport)
//   frame_start      in   frame request pulse
//   pld_len          in   signal+payload sample count, latched with frame_start
//   di_preamble_*    in   preamble sample stream (re, im, vld) / rdy out
//   di_sigpld_*      in   signal/payload sample stream (re, im, vld) / rdy out
//   do_re/do_im      out  assembled frame sample
//   do_vld/do_last   out  sample valid pulse / final data sample of the frame
//   busy             out  frame in progress
//   underrun         out  sticky payload underrun flag
//   state_dbg        out  encoded FSM state (0 IDLE, 1 PRE, 2 PLD, 3 GAP)
//
// Modports: slave = frame_mux side, master = driving/observing side.
// ---------------------------------------------------------------------------
interface frame_mux_if #(
    parameter int WIDTH = 12
);
    logic             frame_start;
    logic [13:0]      pld_len;

    logic [WIDTH-1:0] di_preamble_re;
    logic [WIDTH-1:0] di_preamble_im;
    logic             di_preamble_vld;
    logic             di_preamble_rdy;

    logic [WIDTH-1:0] di_sigpld_re;
    logic [WIDTH-1:0] di_sigpld_im;
    logic             di_sigpld_vld;
    logic             di_sigpld_rdy;

    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_vld;
    logic             do_last;

    logic             busy;
    logic             underrun;
    logic [1:0]       state_dbg;

    modport slave (
        input  frame_start, pld_len,
        input  di_preamble_re, di_preamble_im, di_preamble_vld,
        input  di_sigpld_re, di_sigpld_im, di_sigpld_vld,
        output di_preamble_rdy, di_sigpld_rdy,
        output do_re, do_im, do_vld, do_last,
        output busy, underrun, state_dbg
    );

    modport master (
        output frame_start, pld_len,
        output di_preamble_re, di_preamble_im, di_preamble_vld,
        output di_sigpld_re, di_sigpld_im, di_sigpld_vld,
        input  di_preamble_rdy, di_sigpld_rdy,
        input  do_re, do_im, do_vld, do_last,
        input  busy, underrun, state_dbg
    );
endinterface

// File: rtl/frame_mux.sv
// ---------------------------------------------------------------------------
// frame_mux -- assembles an output frame from a preamble stream followed by a
// buffered signal/payload stream, emitting one sample per OUT_DIV-cycle slot.
//
// Parameters
//   WIDTH      : re/im sample width
//   PRE_LEN    : preamble samples per frame
//   FIFO_DEPTH : signal/payload buffer depth in samples (power of two, >= 2)
//   OUT_DIV    : clock cycles per output slot
//   GAP_LEN    : zero samples appended after a frame (GAP build only)
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : frame_mux_if.slave (see rtl/frame_mux_if.sv for the signal list)
//
// Build option
//   FRAME_MUX_GAP_EN : when defined, each frame is followed by GAP_LEN zero
//                      samples (one per slot, do_last low) before IDLE.
//                      When undefined, the GAP state is unreachable.
//
// Handshake: every vld/rdy pair transfers one sample on each rising edge
// where vld and rdy are both high; a source holds its data and vld until the
// transfer happens, and rdy never depends combinationally on vld.
// ---------------------------------------------------------------------------
module frame_mux #(
    parameter int WIDTH      = 12,
    parameter int PRE_LEN    = 320,
    parameter int FIFO_DEPTH = 64,
    parameter int OUT_DIV    = 3,
    parameter int GAP_LEN    = 16
) (
    input  logic       clk,
    input  logic       rst,
    frame_mux_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PLD  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Where the FSM goes once the last data sample of a frame is out.
`ifdef FRAME_MUX_GAP_EN
    localparam state_t FRAME_END = GAP;
`else
    localparam state_t FRAME_END = IDLE;
`endif

    state_t state, state_next;

    // Frame bookkeeping
    logic [SW-1:0]    slot_cnt;
    logic [PW-1:0]    pre_cnt;
    logic [13:0]      pld_len_q;
    logic [13:0]      pld_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             underrun_q;

    // Output registers
    logic [WIDTH-1:0] do_re_q;
    logic [WIDTH-1:0] do_im_q;
    logic             do_vld_q;
    logic             do_last_q;

    // Signal/payload FIFO; pointers carry one extra bit so that full and
    // empty are both exact.
    logic [WIDTH-1:0] mem_re [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_im [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0]      fifo_cnt, fifo_cnt_nxt;
    logic             fifo_empty;
    logic             sigpld_rdy_q;
    logic             push;

    // Combinational FSM outputs
    logic             slot_open;
    logic             slot_fill;
    logic             start_acc;
    logic             pre_rdy;
    logic             pre_acc;
    logic             pop;
    logic             gap_emit;
    logic             underrun_set;
    logic             last_sample;

    // -----------------------------------------------------------------------
    // FIFO status
    // -----------------------------------------------------------------------
    assign push         = bus.di_sigpld_vld & sigpld_rdy_q;
    assign fifo_cnt     = wr_ptr - rd_ptr;
    assign fifo_empty   = (fifo_cnt == '0);
    assign wr_ptr_nxt   = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt   = rd_ptr + {{AW{1'b0}}, pop};
    assign fifo_cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and per-cycle control
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        start_acc    = 1'b0;
        pre_rdy      = 1'b0;
        pre_acc      = 1'b0;
        pop          = 1'b0;
        gap_emit     = 1'b0;
        underrun_set = 1'b0;
        last_sample  = 1'b0;
        slot_open    = (slot_cnt == '0);

        case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    start_acc  = 1'b1;
                    state_next = PRE;
                end
            end

            // Exit decisions use the counters after the final transfer, so
            // the state changes one cycle after the last sample is emitted.
            PRE: begin
                if (pre_cnt != PW'(PRE_LEN)) begin
                    pre_rdy     = slot_open;
                    pre_acc     = slot_open & bus.di_preamble_vld;
                    last_sample = pre_acc && (pre_cnt == PW'(PRE_LEN - 1))
                                  && (pld_len_q == 14'd0);
                end else if (pld_len_q == 14'd0) begin
                    state_next = FRAME_END;
                end else begin
                    state_next = PLD;
                end
            end

            PLD: begin
                if (pld_cnt != pld_len_q) begin
                    if (slot_open) begin
                        if (fifo_empty) begin
                            // Slot stays open (counter holds) until data arrives.
                            underrun_set = 1'b1;
                        end else begin
                            pop         = 1'b1;
                            last_sample = (pld_cnt == pld_len_q - 14'd1);
                        end
                    end
                end else begin
                    state_next = FRAME_END;
                end
            end

            GAP: begin
                if (gap_cnt != GW'(GAP_LEN)) begin
                    gap_emit = slot_open;
                end else begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        slot_fill = pre_acc | pop | gap_emit;
    end

    // -----------------------------------------------------------------------
    // Counters, flags, outputs and FIFO pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt     <= '0;
            pre_cnt      <= '0;
            pld_len_q    <= '0;
            pld_cnt      <= '0;
            gap_cnt      <= '0;
            underrun_q   <= 1'b0;
            do_re_q      <= '0;
            do_im_q      <= '0;
            do_vld_q     <= 1'b0;
            do_last_q    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sigpld_rdy_q <= 1'b0;
        end else begin
            if (start_acc) begin
                pld_len_q  <= bus.pld_len;
                underrun_q <= 1'b0;
            end else if (underrun_set) begin
                underrun_q <= 1'b1;
            end

            // All frame counters sit at zero whenever the FSM is idle, so a
            // new frame always starts with an open slot.
            if (state_next == IDLE) begin
                slot_cnt <= '0;
                pre_cnt  <= '0;
                pld_cnt  <= '0;
                gap_cnt  <= '0;
            end else begin
                if (pre_acc) begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
                if (pop) begin
                    pld_cnt <= pld_cnt + 1'b1;
                end
                if (gap_emit) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                // Free-running through the closed part of the slot; held at
                // zero while an open slot waits for a sample.
                if (!slot_open || slot_fill) begin
                    slot_cnt <= (slot_cnt == SW'(OUT_DIV - 1)) ? '0 : slot_cnt + 1'b1;
                end
            end

            do_vld_q  <= slot_fill;
            do_last_q <= last_sample;
            if (pre_acc) begin
                do_re_q <= bus.di_preamble_re;
                do_im_q <= bus.di_preamble_im;
            end else if (pop) begin
                do_re_q <= mem_re[rd_ptr[AW-1:0]];
                do_im_q <= mem_im[rd_ptr[AW-1:0]];
            end else if (gap_emit) begin
                do_re_q <= '0;
                do_im_q <= '0;
            end

            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            // Registered ready: reflects occupancy after this cycle, so a full
            // FIFO refuses a push even in a cycle that also pops.
            sigpld_rdy_q <= (fifo_cnt_nxt != CW'(FIFO_DEPTH));
        end
    end

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_re[wr_ptr[AW-1:0]] <= bus.di_sigpld_re;
            mem_im[wr_ptr[AW-1:0]] <= bus.di_sigpld_im;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.di_preamble_rdy = pre_rdy;
    assign bus.di_sigpld_rdy   = sigpld_rdy_q;
    assign bus.do_re           = do_re_q;
    assign bus.do_im           = do_im_q;
    assign bus.do_vld          = do_vld_q;
    assign bus.do_last         = do_last_q;
    assign bus.busy            = (state != IDLE);
    assign bus.underrun        = underrun_q;
    assign bus.state_dbg       = state;

endmodule

// File: tb/tb_frame_mux.sv
// ---------------------------------------------------------------------------
// tb_frame_mux -- self-checking bench for frame_mux.
// Expected output samples are queued when a frame is issued; a monitor on
// the falling edge pops and compares every do_vld sample.
// Define FRAME_MUX_GAP_EN for both files to exercise the GAP build.
// ---------------------------------------------------------------------------
module tb_frame_mux;
    localparam int W       = 12;
    localparam int PRE_LEN = 320;
    localparam int DEPTH   = 64;
    localparam int DIV     = 3;
    localparam int GAP_LEN = 16;
`ifdef FRAME_MUX_GAP_EN
    localparam int BUSY_AFTER_LAST = 1;
`else
    localparam int BUSY_AFTER_LAST = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_mux_if #(.WIDTH(W)) bus ();

    frame_mux #(
        .WIDTH      (W),
        .PRE_LEN    (PRE_LEN),
        .FIFO_DEPTH (DEPTH),
        .OUT_DIV    (DIV),
        .GAP_LEN    (GAP_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [2*W:0] exp_q[$];       // {do_last, do_re, do_im}
    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int vld_cnt = 0;
    int last_vld_cycle = -1;
    bit spacing_on = 1'b0;
    bit busy_chk_next = 1'b0;

    // ---------------- sample patterns ----------------
    function automatic logic [W-1:0] pre_re(input int k);
        return W'(k * 5 + 3);
    endfunction
    function automatic logic [W-1:0] pre_im(input int k);
        return W'(4095 - k);
    endfunction
    function automatic logic [W-1:0] pl_re(input int s);
        return W'(2048 + s);
    endfunction
    function automatic logic [W-1:0] pl_im(input int s);
        return W'(s * 7 + 1);
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Queue the full expected response of one frame.
    task automatic expect_frame(input int len, input int seq0);
        logic lst;
        for (int k = 0; k < PRE_LEN; k++) begin
            lst = (len == 0) && (k == PRE_LEN - 1);
            exp_q.push_back({lst, pre_re(k), pre_im(k)});
        end
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            exp_q.push_back({lst, pl_re(seq0 + i), pl_im(seq0 + i)});
        end
`ifdef FRAME_MUX_GAP_EN
        for (int g = 0; g < GAP_LEN; g++) begin
            exp_q.push_back('0);
        end
`endif
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2*W:0] act;
        logic [2*W:0] req;
        cycle++;
        if (busy_chk_next) begin
            busy_chk_next = 1'b0;
            check("busy_after_last", int'(bus.busy), BUSY_AFTER_LAST);
        end
        if (bus.do_vld === 1'b1) begin
            act = {bus.do_last, bus.do_re, bus.do_im};
            vld_cnt++;
            if (spacing_on && last_vld_cycle >= 0) begin
                check("vld_spacing", cycle - last_vld_cycle, DIV);
            end
            last_vld_cycle = cycle;
            if (bus.do_last === 1'b1) begin
                check("busy_at_last", int'(bus.busy), 1);
                busy_chk_next = 1'b1;
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got last=%0b re=%0h im=%0h, required no output",
                         act[2*W], act[2*W-1:W], act[W-1:0]);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    fails++;
                    $display("FAIL sample #%0d: got last=%0b re=%0h im=%0h, required last=%0b re=%0h im=%0h",
                             vld_cnt, act[2*W], act[2*W-1:W], act[W-1:0],
                             req[2*W], req[2*W-1:W], req[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic start_frame(input int len);
        bus.frame_start = 1'b1;
        bus.pld_len     = 14'(len);
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic feed_pre(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            bus.di_preamble_vld = 1'b1;
            bus.di_preamble_re  = pre_re(k);
            bus.di_preamble_im  = pre_im(k);
            while (bus.di_preamble_rdy !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                tests++;
                fails++;
                $display("FAIL pre_feed: sample %0d, rdy got %0b, required 1", k, bus.di_preamble_rdy);
                bus.di_preamble_vld = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.di_preamble_vld = 1'b0;
    endtask

    task automatic push_sigpld(input int n, input int seq0);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            bus.di_sigpld_vld = 1'b1;
            bus.di_sigpld_re  = pl_re(seq0 + i);
            bus.di_sigpld_im  = pl_im(seq0 + i);
            while (bus.di_sigpld_rdy !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                tests++;
                fails++;
                $display("FAIL sigpld_push: sample %0d, rdy got %0b, required 1", seq0 + i, bus.di_sigpld_rdy);
                bus.di_sigpld_vld = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.di_sigpld_vld = 1'b0;
    endtask

    task automatic wait_queue(input string name, input int level, input int limit);
        int t;
        t = 0;
        while (exp_q.size() > level && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), level);
        if (level == 0) exp_q.delete();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, int'(bus.busy), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    int v0;
    initial begin
        rst                 = 1'b1;
        bus.frame_start     = 1'b0;
        bus.pld_len         = '0;
        bus.di_preamble_re  = '0;
        bus.di_preamble_im  = '0;
        bus.di_preamble_vld = 1'b0;
        bus.di_sigpld_re    = '0;
        bus.di_sigpld_im    = '0;
        bus.di_sigpld_vld   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sig_rdy", int'(bus.di_sigpld_rdy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("sig_rdy_after_release", int'(bus.di_sigpld_rdy), 1);

        // ---- reset in the middle of PRE ----
        for (int k = 0; k < 10; k++) exp_q.push_back({1'b0, pre_re(k), pre_im(k)});
        start_frame(0);
        feed_pre(10);
        wait_queue("pre10_drain", 0, 50);
        check("midpre_state", int'(bus.state_dbg), 1);
        rst = 1'b1;
        #1;
        check("midrst_do_vld", int'(bus.do_vld), 0);
        check("midrst_do_last", int'(bus.do_last), 0);
        check("midrst_do_re", int'(bus.do_re), 0);
        check("midrst_do_im", int'(bus.do_im), 0);
        check("midrst_pre_rdy", int'(bus.di_preamble_rdy), 0);
        check("midrst_sig_rdy", int'(bus.di_sigpld_rdy), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_underrun", int'(bus.underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        v0 = vld_cnt;
        bus.di_preamble_vld = 1'b1;
        repeat (30) @(negedge clk);
        bus.di_preamble_vld = 1'b0;
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_no_vld", vld_cnt - v0, 0);

        // ---- nominal frame, pld_len = 100 ----
        v0 = vld_cnt;
        last_vld_cycle = -1;
        spacing_on = 1'b1;
        expect_frame(100, 0);
        fork
            start_frame(100);
            feed_pre(PRE_LEN);
            push_sigpld(100, 0);
        join
        wait_queue("nominal_drain", 0, 2000);
        wait_idle("nominal_idle", 200);
        spacing_on = 1'b0;
        check("nominal_count", vld_cnt - v0, 420 + BUSY_AFTER_LAST * GAP_LEN);

        // ---- backpressure: 70 samples before frame_start ----
        push_sigpld(63, 100);
        check("bp_rdy_at_63", int'(bus.di_sigpld_rdy), 1);
        push_sigpld(1, 163);
        check("bp_rdy_at_64", int'(bus.di_sigpld_rdy), 0);
        repeat (5) @(negedge clk);
        check("bp_rdy_held", int'(bus.di_sigpld_rdy), 0);
        v0 = vld_cnt;
        expect_frame(70, 100);
        fork
            push_sigpld(6, 164);
            feed_pre(PRE_LEN);
            start_frame(70);
        join
        wait_queue("bp_drain", 0, 2000);
        wait_idle("bp_idle", 200);
        check("bp_count", vld_cnt - v0, 390 + BUSY_AFTER_LAST * GAP_LEN);

        // ---- underrun: pld_len = 10, only 5 samples at first ----
        v0 = vld_cnt;
        expect_frame(10, 200);
        fork
            start_frame(10);
            feed_pre(PRE_LEN);
            push_sigpld(5, 200);
        join
        wait_queue("ur_first5", 5 + BUSY_AFTER_LAST * GAP_LEN, 2000);
        repeat (30) @(negedge clk);
        check("ur_flag", int'(bus.underrun), 1);
        check("ur_state_pld", int'(bus.state_dbg), 2);
        check("ur_stalled", exp_q.size(), 5 + BUSY_AFTER_LAST * GAP_LEN);
        push_sigpld(5, 205);
        wait_queue("ur_drain", 0, 500);
        wait_idle("ur_idle", 200);
        check("ur_sticky", int'(bus.underrun), 1);
        check("ur_count", vld_cnt - v0, 330 + BUSY_AFTER_LAST * GAP_LEN);

        // ---- pld_len = 0 and an ignored frame_start while busy ----
        v0 = vld_cnt;
        expect_frame(0, 0);
        start_frame(0);
        check("ur_cleared", int'(bus.underrun), 0);
        fork
            feed_pre(PRE_LEN);
            begin
                repeat (50) @(negedge clk);
                start_frame(100);
            end
        join
        wait_queue("len0_drain", 0, 500);
        wait_idle("len0_idle", 200);
        repeat (30) @(negedge clk);
        check("len0_count", vld_cnt - v0, 320 + BUSY_AFTER_LAST * GAP_LEN);
        check("len0_busy_stays_low", int'(bus.busy), 0);

`ifdef FRAME_MUX_GAP_EN
        // ---- gap build: pld_len = 4 -> 324 data + 16 zeros ----
        v0 = vld_cnt;
        expect_frame(4, 300);
        fork
            start_frame(4);
            feed_pre(PRE_LEN);
            push_sigpld(4, 300);
        join
        wait_queue("gap_drain", 0, 500);
        wait_idle("gap_idle", 200);
        check("gap_count", vld_cnt - v0, 340);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
